bcd_range_counter: RTL and testbench
====================================

// Module: bcd_range_counter
// PURPOSE
//   Parametrised N-digit BCD counter that steps through [MIN_VAL..MAX_VAL] in
//   either direction and wraps. Advances once per cycle with tick_en high,
//   normally driven by the clockDivider output. Drives per-digit sevenSeg
//   decoders, with a leading-zero blank mask. Provides a wrap pulse, a
//   heartbeat toggle for an LED, and a synchronous parallel load.
// PARAMETERS
//   DIGITS   2   number of BCD digits (1..6); count width = 4*DIGITS
//   MIN_VAL  1   lowest count, as a decimal integer
//   MAX_VAL  99  highest count, decimal; elaboration error unless
//                0 <= MIN_VAL < MAX_VAL <= 10**DIGITS-1
// PORTS
//   clock     in   1         system clock, rising-edge
//   reset_n   in   1         asynchronous active-low reset
//   tick_en   in   1         advance count by one step this cycle
//   dir_up    in   1         1 = count up, 0 = count down (sampled with tick_en)
//   load      in   1         synchronous load request
//   load_val  in   4*DIGITS  BCD value to load; digit i = [4i+3:4i]
//   count     out  4*DIGITS  current BCD count, registered
//   blank     out  DIGITS    1 = digit i is a leading zero (blank it on the display)
//   wrap      out  1         one-cycle pulse, registered, on a wrap-around step
//   load_err  out  1         one-cycle pulse, registered, on a rejected load
//   toggle    out  1         flips on every accepted advance (heartbeat LED)
// BEHAVIOUR
//   Reset (async assert, sync-safe release)
//     count = BCD(MIN_VAL); blank = leading-zero mask of MIN_VAL.
//     wrap = 0; load_err = 0; toggle = 0.
//   Priority per rising edge: load > tick_en > hold.
//   Load
//     Accepted only if every digit is <= 9 and MIN_VAL <= value <= MAX_VAL.
//     Accepted: count = load_val on the next edge. toggle and wrap unchanged.
//     Rejected: count holds; load_err = 1 for exactly one cycle.
//     A tick_en asserted in the same cycle is discarded, not deferred.
//   Advance (tick_en = 1, load = 0)
//     Up: count + 1, with per-digit BCD carry (9 -> 0, carry into the next digit).
//       At MAX_VAL the next count is MIN_VAL and wrap = 1.
//     Down: count - 1, with per-digit BCD borrow (0 -> 9).
//       At MIN_VAL the next count is MAX_VAL and wrap = 1.
//     toggle inverts on every advance, including wrap steps.
//   Latency: count, blank, wrap and toggle all reflect an advance on the same
//     edge that samples tick_en (1 cycle). wrap and load_err are low otherwise.
//   Blank mask
//     blank[i] = 1 iff digit i and all digits above it are 0, for i >= 1.
//     blank[0] is always 0, so the value 0 shows as "0".
//     Registered together with count; never combinationally from inputs.
//   Held inputs
//     tick_en held high advances every cycle; no edge detection.
//     dir_up may change between ticks. A direction change at a bound
//     produces no wrap (e.g. MAX, down -> MAX-1).
//   Reset mid-operation: all state returns to reset values immediately,
//     independent of clock; pending load or tick is lost.
//   Arithmetic: no binary intermediate; all bound compares are digit-wise BCD.
// STRUCTURE
//   Shared package bcd_pkg
//     BCD_W = 4; BCD_MAX_DIGIT = 4'd9.
//     Function to_bcd(int, digits) for parameter -> BCD constant conversion.
//   Sub-module bcd_digit, one per digit (generate loop).
//     Inputs: inc, dec, load, load_digit.
//     Outputs: digit, carry_out (9 while inc), borrow_out (0 while dec).
//     Chained carry/borrow from the LSD upwards.
//   Top level: bound compare (==MIN, ==MAX), wrap override, load validation,
//     blank mask, toggle/pulse registers.
// TESTING
//   1 Defaults (2 digits, 1..99), dir_up=1, 99 ticks from reset:
//     count 01..99, then 01. wrap high only on the 99->01 edge. toggle = 1 after 99 ticks.
//   2 dir_up=0 from reset (01): one tick -> 99 with wrap=1; next tick -> 98.
//     blank = 2'b10 while count = 0x05.
//   3 load 0x42 with tick_en=1 in the same cycle:
//     count = 0x42, toggle unchanged. Next tick up -> 0x43.
//   4 load 0x4A (invalid digit), then load 0x00 (below MIN_VAL):
//     count holds, load_err pulses 1 cycle for each load.
//   5 Carry chain: DIGITS=3, MIN=0, MAX=999, load 0x199, tick up -> 0x200.
//     Then tick down -> 0x199; from 0x000 tick down -> 0x999 with wrap.
//   6 Assert reset_n low mid-stream, between edges:
//     count = 0x01, toggle = 0 immediately. After release, first tick -> 0x02.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the range counter: decimal-to-BCD
// conversion for parameters and the leading-zero blank mask.
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam int MAX_DIGITS = 6;

    // Decimal integer to packed BCD, digit i in bits [4i+3:4i].
    function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input int value, input int digits);
        logic [4*MAX_DIGITS-1:0] bcd;
        int rem;
        bcd = '0;
        rem = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                bcd[BCD_W*i +: BCD_W] = 4'(rem % 10);
                rem = rem / 10;
            end else begin
                bcd[BCD_W*i +: BCD_W] = 4'd0;
            end
        end
        return bcd;
    endfunction

    // Digit i (i >= 1) blanks when it and every digit above it are zero.
    function automatic logic [MAX_DIGITS-1:0] blank_mask(input logic [4*MAX_DIGITS-1:0] bcd,
                                                         input int digits);
        logic [MAX_DIGITS-1:0] mask;
        logic zero_above;
        mask = '0;
        zero_above = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (i < digits) begin
                zero_above = zero_above & (bcd[BCD_W*i +: BCD_W] == 4'd0);
                mask[i] = (i >= 1) ? zero_above : 1'b0;
            end else begin
                mask[i] = 1'b0;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with load, increment and decrement; carry/borrow
// outputs chain into the next more-significant digit.
module bcd_digit
    import bcd_pkg::*;
#(
    parameter logic [3:0] RESET_DIGIT = 4'd0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  logic [3:0] load_digit,
    output logic [3:0] digit,
    output logic [3:0] next_digit,
    output logic       carry_out,
    output logic       borrow_out
);

    logic [3:0] digit_r;
    logic [3:0] next_digit_s;

    // Next-digit selection: load overrides stepping.
    always_comb begin
        next_digit_s = digit_r;
        if (load) begin
            next_digit_s = load_digit;
        end else if (inc) begin
            next_digit_s = (digit_r == BCD_MAX_DIGIT) ? 4'd0 : digit_r + 4'd1;
        end else if (dec) begin
            next_digit_s = (digit_r == 4'd0) ? BCD_MAX_DIGIT : digit_r - 4'd1;
        end else begin
            next_digit_s = digit_r;
        end
    end

    // Digit state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digit_r <= RESET_DIGIT;
        end else begin
            digit_r <= next_digit_s;
        end
    end

    assign digit      = digit_r;
    assign next_digit = next_digit_s;
    assign carry_out  = inc & (digit_r == BCD_MAX_DIGIT);
    assign borrow_out = dec & (digit_r == 4'd0);

endmodule

// File: rtl/bcd_range_counter.sv
// N-digit BCD up/down counter over [MIN_VAL..MAX_VAL] with wrap, validated
// parallel load, leading-zero blank mask and a heartbeat toggle.
module bcd_range_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MIN_VAL = 1,
    parameter int MAX_VAL = 99
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  tick_en,
    input  logic                  dir_up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic [DIGITS-1:0]     blank,
    output logic                  wrap,
    output logic                  load_err,
    output logic                  toggle
);

    localparam int CW    = BCD_W * DIGITS;
    localparam int LIMIT = (10 ** DIGITS) - 1;
    localparam logic [CW-1:0]     MIN_BCD   = CW'(to_bcd(MIN_VAL, DIGITS));
    localparam logic [CW-1:0]     MAX_BCD   = CW'(to_bcd(MAX_VAL, DIGITS));
    localparam logic [DIGITS-1:0] BLANK_RST = DIGITS'(blank_mask(to_bcd(MIN_VAL, DIGITS), DIGITS));

    if (!(DIGITS >= 1 && DIGITS <= MAX_DIGITS && MIN_VAL >= 0 &&
          MIN_VAL < MAX_VAL && MAX_VAL <= LIMIT)) begin : g_param_error
        $error("bcd_range_counter: illegal DIGITS/MIN_VAL/MAX_VAL combination");
    end

    logic [CW-1:0]     count_s;
    logic [CW-1:0]     next_count_s;
    logic [CW-1:0]     load_digit_s;
    logic [DIGITS:0]   inc_chain_s;
    logic [DIGITS:0]   dec_chain_s;
    logic              digits_ok_s;
    logic              load_ok_s;
    logic              tick_step_s;
    logic              wrap_step_s;
    logic              digit_load_s;
    logic [DIGITS-1:0] blank_r;
    logic              wrap_r;
    logic              load_err_r;
    logic              toggle_r;
    logic              unused_chain_s;

    // Load validation and step control. With every digit <= 9, an unsigned
    // compare of packed BCD equals a digit-wise compare from the MSD down.
    always_comb begin
        digits_ok_s = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[BCD_W*i +: BCD_W] > BCD_MAX_DIGIT) begin
                digits_ok_s = 1'b0;
            end else begin
                digits_ok_s = digits_ok_s;
            end
        end
        load_ok_s    = load & digits_ok_s & (load_val >= MIN_BCD) & (load_val <= MAX_BCD);
        tick_step_s  = tick_en & ~load;
        wrap_step_s  = tick_step_s & (dir_up ? (count_s == MAX_BCD) : (count_s == MIN_BCD));
        digit_load_s = load_ok_s | wrap_step_s;
        load_digit_s = load ? load_val : (dir_up ? MIN_BCD : MAX_BCD);
        inc_chain_s[0] = tick_step_s & dir_up & ~wrap_step_s;
        dec_chain_s[0] = tick_step_s & ~dir_up & ~wrap_step_s;
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit #(
            .RESET_DIGIT(MIN_BCD[BCD_W*i +: BCD_W])
        ) u_digit (
            .clock      (clock),
            .reset_n    (reset_n),
            .inc        (inc_chain_s[i]),
            .dec        (dec_chain_s[i]),
            .load       (digit_load_s),
            .load_digit (load_digit_s[BCD_W*i +: BCD_W]),
            .digit      (count_s[BCD_W*i +: BCD_W]),
            .next_digit (next_count_s[BCD_W*i +: BCD_W]),
            .carry_out  (inc_chain_s[i+1]),
            .borrow_out (dec_chain_s[i+1])
        );
    end

    assign unused_chain_s = inc_chain_s[DIGITS] ^ dec_chain_s[DIGITS];

    // Blank mask, pulses and heartbeat, registered alongside the digits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blank_r    <= BLANK_RST;
            wrap_r     <= 1'b0;
            load_err_r <= 1'b0;
            toggle_r   <= 1'b0;
        end else begin
            blank_r    <= DIGITS'(blank_mask(24'(next_count_s), DIGITS));
            wrap_r     <= wrap_step_s;
            load_err_r <= load & ~load_ok_s;
            toggle_r   <= toggle_r ^ tick_step_s;
        end
    end

    assign count    = count_s;
    assign blank    = blank_r;
    assign wrap     = wrap_r;
    assign load_err = load_err_r;
    assign toggle   = toggle_r;

endmodule

// File: tb/tb_bcd_range_counter.sv
// Randomised and directed bench for bcd_range_counter (2-digit 1..99 and
// 3-digit 0..999 instances) against an integer reference model.
module tb_bcd_range_counter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        tick_a, dir_a, load_a;
    logic [7:0]  lval_a;
    logic [7:0]  count_a;
    logic [1:0]  blank_a;
    logic        wrap_a, lerr_a, tog_a;
    logic        tick_b, dir_b, load_b;
    logic [11:0] lval_b;
    logic [11:0] count_b;
    logic [2:0]  blank_b;
    logic        wrap_b, lerr_b, tog_b;

    int checks = 0;
    int errors = 0;

    int mn[2] = '{1, 0};
    int mx[2] = '{99, 999};
    int nd[2] = '{2, 3};
    int m_val[2];
    int m_tog[2];
    int m_wrap[2];
    int m_lerr[2];

    always #5 clock = ~clock;

    bcd_range_counter #(.DIGITS(2), .MIN_VAL(1), .MAX_VAL(99)) dut_a (
        .clock(clock), .reset_n(reset_n), .tick_en(tick_a), .dir_up(dir_a),
        .load(load_a), .load_val(lval_a), .count(count_a), .blank(blank_a),
        .wrap(wrap_a), .load_err(lerr_a), .toggle(tog_a)
    );

    bcd_range_counter #(.DIGITS(3), .MIN_VAL(0), .MAX_VAL(999)) dut_b (
        .clock(clock), .reset_n(reset_n), .tick_en(tick_b), .dir_up(dir_b),
        .load(load_b), .load_val(lval_b), .count(count_b), .blank(blank_b),
        .wrap(wrap_b), .load_err(lerr_b), .toggle(tog_b)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dec_to_bcd(input int v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_blank(input int v, input int digits);
        logic [31:0] b;
        b = '0;
        for (int i = 1; i < digits; i++) b[i] = (v < 10 ** i);
        return b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_val[k] = mn[k]; m_tog[k] = 0; m_wrap[k] = 0; m_lerr[k] = 0;
        end
    endtask

    // Advance the integer model by one clock edge using the present inputs.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] lv;
            logic ld, tk, up, ok;
            int v;
            lv = (k == 0) ? 32'(lval_a) : 32'(lval_b);
            ld = (k == 0) ? load_a : load_b;
            tk = (k == 0) ? tick_a : tick_b;
            up = (k == 0) ? dir_a : dir_b;
            m_wrap[k] = 0;
            m_lerr[k] = 0;
            if (ld) begin
                ok = 1'b1;
                v = 0;
                for (int i = 0; i < nd[k]; i++) begin
                    if (lv[4*i +: 4] > 4'd9) ok = 1'b0;
                    v += int'(lv[4*i +: 4]) * (10 ** i);
                end
                if (v < mn[k] || v > mx[k]) ok = 1'b0;
                if (ok) m_val[k] = v;
                else m_lerr[k] = 1;
            end else if (tk) begin
                m_tog[k] ^= 1;
                if (up) begin
                    if (m_val[k] == mx[k]) begin m_val[k] = mn[k]; m_wrap[k] = 1; end
                    else m_val[k]++;
                end else begin
                    if (m_val[k] == mn[k]) begin m_val[k] = mx[k]; m_wrap[k] = 1; end
                    else m_val[k]--;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check_value({tag, ".count_a"}, 32'(count_a), dec_to_bcd(m_val[0]));
        check_value({tag, ".blank_a"}, 32'(blank_a), exp_blank(m_val[0], 2));
        check_value({tag, ".wrap_a"},  32'(wrap_a),  32'(m_wrap[0]));
        check_value({tag, ".lerr_a"},  32'(lerr_a),  32'(m_lerr[0]));
        check_value({tag, ".tog_a"},   32'(tog_a),   32'(m_tog[0]));
        check_value({tag, ".count_b"}, 32'(count_b), dec_to_bcd(m_val[1]));
        check_value({tag, ".blank_b"}, 32'(blank_b), exp_blank(m_val[1], 3));
        check_value({tag, ".wrap_b"},  32'(wrap_b),  32'(m_wrap[1]));
        check_value({tag, ".lerr_b"},  32'(lerr_b),  32'(m_lerr[1]));
        check_value({tag, ".tog_b"},   32'(tog_b),   32'(m_tog[1]));
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        tick_a = 1'b0; dir_a = 1'b1; load_a = 1'b0; lval_a = 8'h00;
        tick_b = 1'b0; dir_b = 1'b1; load_b = 1'b0; lval_b = 12'h000;
    endtask

    task automatic apply_reset(input string tag);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b1;
        #2;
        apply_reset("reset");

        // Count up through the full range and wrap once.
        tick_a = 1'b1; dir_a = 1'b1;
        for (int n = 0; n < 99; n++) cycle("up_run");
        check_value("up_run_end_count", 32'(count_a), 32'h01);
        check_value("up_run_end_toggle", 32'(tog_a), 32'd1);
        tick_a = 1'b0;

        // Down from MIN wraps to MAX, then steps down to 05.
        apply_reset("reset2");
        tick_a = 1'b1; dir_a = 1'b0;
        cycle("down_wrap");
        check_value("down_wrap_count", 32'(count_a), 32'h99);
        check_value("down_wrap_pulse", 32'(wrap_a), 32'd1);
        for (int n = 0; n < 94; n++) cycle("down_run");
        check_value("down_05_count", 32'(count_a), 32'h05);
        check_value("down_05_blank", 32'(blank_a), 32'h2);
        tick_a = 1'b0;

        // Load beats a same-cycle tick; then invalid loads are rejected.
        load_a = 1'b1; lval_a = 8'h42; tick_a = 1'b1;
        cycle("load42");
        check_value("load42_count", 32'(count_a), 32'h42);
        load_a = 1'b0; dir_a = 1'b1;
        cycle("after_load");
        tick_a = 1'b0;
        load_a = 1'b1; lval_a = 8'h4A;
        cycle("load_bad_digit");
        load_a = 1'b0;
        cycle("lerr_clear1");
        load_a = 1'b1; lval_a = 8'h00;
        cycle("load_below_min");
        check_value("load_below_min_count", 32'(count_a), 32'h43);
        load_a = 1'b0;
        cycle("lerr_clear2");

        // Three-digit carry and borrow chain.
        load_b = 1'b1; lval_b = 12'h199;
        cycle("b_load199");
        load_b = 1'b0; tick_b = 1'b1; dir_b = 1'b1;
        cycle("b_carry");
        check_value("b_carry_count", 32'(count_b), 32'h200);
        dir_b = 1'b0;
        cycle("b_borrow");
        tick_b = 1'b0; load_b = 1'b1; lval_b = 12'h000;
        cycle("b_load000");
        load_b = 1'b0; tick_b = 1'b1;
        cycle("b_wrap");
        check_value("b_wrap_count", 32'(count_b), 32'h999);
        tick_b = 1'b0;

        // Reset asserted between edges while ticking.
        tick_a = 1'b1; dir_a = 1'b1;
        for (int n = 0; n < 5; n++) cycle("pre_reset");
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("mid_reset");
        check_value("mid_reset_count", 32'(count_a), 32'h01);
        #2;
        reset_n = 1'b1;
        cycle("post_reset");
        check_value("post_reset_count", 32'(count_a), 32'h02);

        // Random mix of ticks, direction changes and loads.
        for (int n = 0; n < 600; n++) begin
            tick_a = ($urandom_range(0, 3) != 0);
            dir_a  = $urandom_range(0, 1) == 1;
            load_a = ($urandom_range(0, 11) == 0);
            lval_a = ($urandom_range(0, 1) == 1) ? 8'(dec_to_bcd($urandom_range(0, 99)))
                                                 : 8'($urandom_range(0, 255));
            tick_b = ($urandom_range(0, 3) != 0);
            dir_b  = $urandom_range(0, 1) == 1;
            load_b = ($urandom_range(0, 11) == 0);
            lval_b = ($urandom_range(0, 1) == 1) ? 12'(dec_to_bcd($urandom_range(0, 999)))
                                                 : 12'($urandom_range(0, 4095));
            cycle("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
